uart_autobaud_ctrl: RTL and testbench
=====================================

# uart_autobaud_ctrl

Auto-baud controller that sets the `baudrate_cfg` value driven into the UART baud generator. In manual mode it passes a software divisor through. In auto mode it waits for an idle line, then times one 0x55 sync character on `rx`. It computes the divisor that makes the generator's `rx_clk_en` tick `SAMPLE_RATE` times per bit. It sits between the register block and the baud generator and is clocked in the same domain.

## Interface
- `CLK_FREQ`, 50000000, system clock frequency in Hz; informational only.
- `SAMPLE_RATE`, 24, `rx_clk_en` ticks per bit; must match the generator.
- `IDLE_CYCLES`, 256, consecutive high `rx` cycles required before arming the start-edge search.

- `clk` input 1: system clock.
- `rstb` input 1: asynchronous active-low reset.
- `rx` input 1: asynchronous serial line.
- `auto_en` input 1: level. 1 selects auto-baud mode; 0 selects manual mode.
- `start` input 1: single-cycle pulse that starts a detection.
- `manual_cfg` input 8: software divisor.
- `baudrate_cfg` output 8: registered divisor to the baud generator.
- `busy` output 1: detection in progress.
- `locked` output 1: auto divisor valid and in use.
- `done` output 1: one-cycle pulse on successful lock.
- `err` output 1: one-cycle pulse on detection failure.

## Operation
- `rx` passes through a 2-flop synchronizer (`rxs`). Edges are detected against a delayed copy of `rxs`.
- FSM states are IDLE, WAIT_IDLE, WAIT_START, MEASURE, WAIT_STOP and LOCKED.
- **IDLE / LOCKED**
  - `start` with `auto_en`=1 moves to WAIT_IDLE and clears `locked`.
  - `start` is ignored in every other state, and whenever `auto_en`=0.
- **WAIT_IDLE**
  - An idle counter increments while `rxs`=1 and clears to 0 on `rxs`=0.
  - When the count reaches `IDLE_CYCLES`, the FSM moves to WAIT_START.
- **WAIT_START**
  - The first falling edge moves to MEASURE.
  - On entry to MEASURE: prescaler `p`=4·`SAMPLE_RATE`, quotient `q`(9 bits)=0, edge count=0.
  - There is no timeout in this state.
- **MEASURE**
  - `p` increments every cycle.
  - When `p`=8·`SAMPLE_RATE`−1, `p` wraps to 0 and `q` increments.
  - Each falling edge increments the edge count.
  - On the 4th falling edge after the start edge (bit 7 of 0x55): go to WAIT_STOP if 1≤`q`≤256, otherwise go to IDLE with `err`.
  - If `q` would reach 257, go to IDLE with `err` immediately.
  - Result: `q` = floor((T+4·SR)/(8·SR)) = round(T/(8·SR)), where T is the cycle count between the start edge and the final edge.
- **WAIT_STOP**
  - A rising edge latches `auto_cfg`=`q`−1 and moves to LOCKED with `done`.
  - If `rxs` stays low for 2·`q`·`SAMPLE_RATE` cycles, go to IDLE with `err`.
  - This timeout uses a counter wrapping at `q`−1 and a tick counter reaching 2·`SAMPLE_RATE`. No multiplier.
- **Output selection**
  - `baudrate_cfg` ← `manual_cfg` when `auto_en`=0 or `locked`=0.
  - `baudrate_cfg` ← `auto_cfg` when `locked`=1.
- **Abort:** `auto_en` falling in any state forces IDLE and clears `locked`. No `done` or `err` is pulsed.
- **Errors:** `err` always leaves `locked`=0, so the previous auto value is not reused.

## Timing
- Reset values: `baudrate_cfg`=0, `busy`=0, `locked`=0, `done`=0, `err`=0. State=IDLE and all counters are 0.
- `baudrate_cfg` follows `manual_cfg` and `auto_en` with 1 cycle of latency.
- `busy`=1 in WAIT_IDLE, WAIT_START, MEASURE and WAIT_STOP. It is registered and asserts 1 cycle after `start`.
- `rx` to edge detection is 3 cycles. This latency is identical for both measured edges, so T is unaffected.
- On the `done` cycle, `locked`=1 and `busy`=0. `baudrate_cfg` shows `auto_cfg` one cycle later.
- If an error condition and an `auto_en` fall occur in the same cycle, the abort wins and no `err` is pulsed.
- `start` in the same cycle as the FSM enters IDLE from an error is ignored.
- Reset asserted mid-operation returns every output to its reset value immediately, because reset is asynchronous.

## Configuration
- `AUTOBAUD_GLITCH_FILTER_EN`
  - **Defined:** a 3-sample majority filter follows the synchronizer. `rxs` is the filtered value, edge latency becomes 4 cycles, and a single-cycle `rx` pulse never produces an edge.
  - **Undefined:** no filter. A 1-cycle glitch is counted as an edge.

## Test plan
- **Manual pass-through:** reset, then `auto_en`=0, `manual_cfg`=0x1A → `baudrate_cfg`=0x1A after 1 cycle; `locked`=0, `done` and `err` never pulse.
- **115200 baud:** `auto_en`=1, `start`, 300 idle cycles, 0x55 at a 434-cycle bit → `done` after the stop-bit rising edge, `baudrate_cfg`=17, `locked`=1.
- **9600 baud:** 0x55 at a 5208-cycle bit → `baudrate_cfg`=216.
- **Too slow:** 0x55 at a 41667-cycle bit → `err` when `q` hits 257 (about 49248 cycles after the start edge); `locked`=0 and `baudrate_cfg` remains `manual_cfg`.
- **Abort:** drop `auto_en` during MEASURE → IDLE next cycle, `busy`=0, no `done` or `err`. Then re-enable and detect 115200 successfully.
- **Glitch:**
  - Stimulus: a 1-cycle low pulse during WAIT_IDLE, then 0x55 at 434 cycles.
  - With `AUTOBAUD_GLITCH_FILTER_EN`: the idle counter is not cleared and the result is 17.
  - Without it: the idle wait restarts.

Source files
------------

// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl
//   Selects the divisor driven into the UART baud generator. In manual mode
//   the software divisor is passed through. In auto mode the block waits for
//   an idle line, times one 0x55 sync character on rx and derives the divisor
//   that gives SAMPLE_RATE rx_clk_en ticks per bit.
//
//   Optional build macro: AUTOBAUD_GLITCH_FILTER_EN
//     defined   -> 3-sample majority filter after the synchronizer
//     undefined -> synchronized rx used directly
//
// Ports
//   clk          system clock
//   rstb         asynchronous active-low reset
//   rx           asynchronous serial line
//   auto_en      1 = auto-baud mode, 0 = manual mode
//   start        single-cycle pulse that starts a detection
//   manual_cfg   software divisor
//   baudrate_cfg registered divisor to the baud generator
//   busy         detection in progress
//   locked       auto divisor valid and in use
//   done         one-cycle pulse on successful lock
//   err          one-cycle pulse on detection failure
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | no detection running, manual divisor in use
// WAIT_IDLE  | counting consecutive high rx cycles
// WAIT_START | line idle long enough, waiting for the start-bit falling edge
// MEASURE    | timing start edge to the falling edge of data bit 7
// WAIT_STOP  | waiting for the stop-bit rising edge, with timeout
// LOCKED     | auto divisor latched and in use

module uart_autobaud_ctrl #(
    parameter int CLK_FREQ    = 50000000,
    parameter int SAMPLE_RATE = 24,
    parameter int IDLE_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       rx,
    input  logic       auto_en,
    input  logic       start,
    input  logic [7:0] manual_cfg,
    output logic [7:0] baudrate_cfg,
    output logic       busy,
    output logic       locked,
    output logic       done,
    output logic       err
);

    localparam int PW = $clog2(8 * SAMPLE_RATE);
    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int TW = $clog2(2 * SAMPLE_RATE);
    localparam logic [PW-1:0] P_INIT    = PW'(4 * SAMPLE_RATE);
    localparam logic [PW-1:0] P_MAX     = PW'(8 * SAMPLE_RATE - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(2 * SAMPLE_RATE - 1);

    // A clock slower than one tick per sample can never work; this block is
    // a named elaboration hook so the mismatch is visible in the hierarchy.
    if (CLK_FREQ < SAMPLE_RATE) begin : g_clk_freq_too_low
    end

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_IDLE, S_WAIT_START, S_MEASURE, S_WAIT_STOP, S_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_sync_q, rxs_dly_q;
    logic          rxs, fall, rise;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [PW-1:0] p_q, p_d;
    logic [8:0]    q_q, q_d, q_next;
    logic [1:0]    edge_cnt_q, edge_cnt_d;
    logic [8:0]    sub_cnt_q, sub_cnt_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    auto_cfg_q, auto_cfg_d;
    logic [7:0]    baudrate_cfg_q, baudrate_cfg_d;
    logic          busy_q, busy_d, locked_q, locked_d;
    logic          done_q, done_d, err_q, err_d;

    // Synchronizer flops reset to 1 (idle line) so reset release never
    // looks like a falling edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rxs_dly_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rxs_dly_q <= rxs;
        end
    end

`ifdef AUTOBAUD_GLITCH_FILTER_EN
    logic [1:0] rx_hist_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) rx_hist_q <= 2'b11;
        else       rx_hist_q <= {rx_hist_q[0], rx_sync_q};
    end

    // A one-cycle pulse is present in at most one of the three samples.
    assign rxs = (rx_sync_q & rx_hist_q[0]) | (rx_sync_q & rx_hist_q[1]) |
                 (rx_hist_q[0] & rx_hist_q[1]);
`else
    assign rxs = rx_sync_q;
`endif

    assign fall = rxs_dly_q & ~rxs;
    assign rise = ~rxs_dly_q & rxs;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q        <= S_IDLE;
            idle_cnt_q     <= '0;
            p_q            <= '0;
            q_q            <= '0;
            edge_cnt_q     <= '0;
            sub_cnt_q      <= '0;
            tick_q         <= '0;
            auto_cfg_q     <= '0;
            baudrate_cfg_q <= '0;
            busy_q         <= 1'b0;
            locked_q       <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            idle_cnt_q     <= idle_cnt_d;
            p_q            <= p_d;
            q_q            <= q_d;
            edge_cnt_q     <= edge_cnt_d;
            sub_cnt_q      <= sub_cnt_d;
            tick_q         <= tick_d;
            auto_cfg_q     <= auto_cfg_d;
            baudrate_cfg_q <= baudrate_cfg_d;
            busy_q         <= busy_d;
            locked_q       <= locked_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        p_d        = p_q;
        q_d        = q_q;
        q_next     = q_q;
        edge_cnt_d = edge_cnt_q;
        sub_cnt_d  = sub_cnt_q;
        tick_d     = tick_q;
        auto_cfg_d = auto_cfg_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE, S_LOCKED: begin
                if (start && auto_en) begin
                    state_d    = S_WAIT_IDLE;
                    idle_cnt_d = '0;
                end
            end
            S_WAIT_IDLE: begin
                if (!rxs) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    idle_cnt_d = '0;
                    state_d    = S_WAIT_START;
                end else begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
            end
            S_WAIT_START: begin
                if (fall) begin
                    state_d    = S_MEASURE;
                    p_d        = P_INIT;
                    q_d        = '0;
                    edge_cnt_d = '0;
                end
            end
            S_MEASURE: begin
                // Prescaler starts at half a period so q rounds to nearest.
                if (p_q == P_MAX) begin
                    p_d    = '0;
                    q_next = q_q + 9'd1;
                end else begin
                    p_d = p_q + PW'(1);
                end
                q_d = q_next;
                if (q_next == 9'd257) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (fall) begin
                    if (edge_cnt_q == 2'd3) begin
                        if (q_next != 9'd0) begin
                            state_d   = S_WAIT_STOP;
                            sub_cnt_d = '0;
                            tick_d    = '0;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        edge_cnt_d = edge_cnt_q + 2'd1;
                    end
                end
            end
            S_WAIT_STOP: begin
                // Timeout of 2*q*SAMPLE_RATE cycles: q-cycle groups counted
                // up to 2*SAMPLE_RATE.
                if (rise) begin
                    auto_cfg_d = 8'(q_q - 9'd1);
                    state_d    = S_LOCKED;
                    done_d     = 1'b1;
                end else if (sub_cnt_q == q_q - 9'd1) begin
                    sub_cnt_d = '0;
                    if (tick_q == T_LAST) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end else begin
                    sub_cnt_d = sub_cnt_q + 9'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Dropping auto_en overrides everything, including a same-cycle error.
        if (!auto_en && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end

        busy_d   = state_d inside {S_WAIT_IDLE, S_WAIT_START, S_MEASURE, S_WAIT_STOP};
        locked_d = (state_d == S_LOCKED);
        baudrate_cfg_d = (auto_en && locked_q) ? auto_cfg_q : manual_cfg;
    end

    assign baudrate_cfg = baudrate_cfg_q;
    assign busy         = busy_q;
    assign locked       = locked_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
module tb_uart_autobaud_ctrl;

    localparam int SR     = 24;
    localparam int IDLE_N = 256;
`ifdef AUTOBAUD_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic       rx = 1'b1;
    logic       auto_en = 1'b0;
    logic       start = 1'b0;
    logic [7:0] manual_cfg = 8'h00;
    logic [7:0] baudrate_cfg;
    logic       busy, locked, done, err;

    always #5 clk = ~clk;

    uart_autobaud_ctrl #(
        .SAMPLE_RATE(SR),
        .IDLE_CYCLES(IDLE_N)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .rx          (rx),
        .auto_en     (auto_en),
        .start       (start),
        .manual_cfg  (manual_cfg),
        .baudrate_cfg(baudrate_cfg),
        .busy        (busy),
        .locked      (locked),
        .done        (done),
        .err         (err)
    );

    int n_pass = 0;
    int n_total = 0;

    // Pulse monitor: samples 1 time unit after each rising edge.
    int         cyc = 0;
    int         done_cnt = 0, err_cnt = 0;
    int         done_cyc = -1, err_cyc = -1;
    logic       done_lk = 1'b0, done_bz = 1'b0, done_prev = 1'b0;
    logic [7:0] cfg_after_done = 8'h00;

    always @(posedge clk) begin
        cyc++;
        #1;
        if (done_prev) cfg_after_done = baudrate_cfg;
        done_prev = done;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_lk  = locked;
            done_bz  = busy;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Sends start, 8 data bits LSB first, stop. Returns the cycles at which
    // the start bit, data bit 7 and the stop bit were driven.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int bl,
                              output int c_start, output int c_d7, output int c_stop);
        logic [9:0] frame;
        frame = {stop_val, data, 1'b0};
        c_start = 0; c_d7 = 0; c_stop = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) c_start = cyc;
            if (i == 8) c_d7 = cyc;
            if (i == 9) c_stop = cyc;
            rx = frame[i];
            repeat (bl) tick();
        end
    endtask

    // Rounded cycles-per-bit / SR: T spans 8 bit times from start edge to bit 7.
    function automatic int model_q(input int bit_len);
        return (8 * bit_len + 4 * SR) / (8 * SR);
    endfunction

    typedef struct {
        logic       ae;
        logic       st;
        logic [7:0] man;
        logic [7:0] exp_cfg;
        logic       exp_busy;
    } vec_t;

    vec_t vt[6];

    initial begin
        int d0, e0, cs, c7, cst, q, bl, c;
        logic [7:0] prev_cfg, man;
        int bits[7];

        vt[0] = '{1'b0, 1'b0, 8'h1A, 8'h1A, 1'b0};
        vt[1] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0};
        vt[2] = '{1'b1, 1'b0, 8'h3C, 8'h3C, 1'b0};
        vt[3] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
        vt[4] = '{1'b0, 1'b1, 8'h81, 8'h81, 1'b0};
        vt[5] = '{1'b1, 1'b0, 8'h55, 8'h55, 1'b0};

        // Reset state
        repeat (3) tick();
        chk("reset_cfg", baudrate_cfg, 0);
        chk("reset_busy", busy, 0);
        chk("reset_locked", locked, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        rstb = 1'b1;
        tick();

        // Manual pass-through table
        prev_cfg = 8'h00;
        for (int i = 0; i < 6; i++) begin
            auto_en    = vt[i].ae;
            start      = vt[i].st;
            manual_cfg = vt[i].man;
            chk("tbl_cfg_hold", baudrate_cfg, prev_cfg);
            tick();
            start = 1'b0;
            chk("tbl_cfg", baudrate_cfg, vt[i].exp_cfg);
            chk("tbl_busy", busy, vt[i].exp_busy);
            chk("tbl_locked", locked, 0);
            prev_cfg = vt[i].exp_cfg;
        end
        chk("tbl_no_done", done_cnt, 0);
        chk("tbl_no_err", err_cnt, 0);

        // Glitch during the idle wait
        d0 = done_cnt; e0 = err_cnt;
        auto_en = 1'b1; manual_cfg = 8'h33;
        pulse_start();
        chk("glitch_busy", busy, 1);
        idle(99);
        rx = 1'b0;
        tick();
        idle(200);
        send_frame(8'h55, 1'b1, 434, cs, c7, cst);
        idle(5);
`ifdef AUTOBAUD_GLITCH_FILTER_EN
        chk("glitch_done", done_cnt - d0, 1);
        chk("glitch_cfg", baudrate_cfg, 17);
        chk("glitch_locked", locked, 1);
`else
        chk("glitch_done", done_cnt - d0, 0);
        chk("glitch_busy_still", busy, 1);
        chk("glitch_locked", locked, 0);
`endif
        auto_en = 1'b0;
        tick();
        chk("glitch_abort_busy", busy, 0);
        tick();
        chk("glitch_abort_cfg", baudrate_cfg, 8'h33);
        chk("glitch_no_err", err_cnt - e0, 0);

        // Abort during MEASURE, then a clean 115200 detection
        d0 = done_cnt; e0 = err_cnt;
        auto_en = 1'b1;
        pulse_start();
        idle(300);
        rx = 1'b0;
        repeat (434) tick();
        rx = 1'b1;
        repeat (434) tick();
        auto_en = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_locked", locked, 0);
        idle(10);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_no_err", err_cnt - e0, 0);

        auto_en = 1'b1; manual_cfg = 8'h44;
        tick();
        pulse_start();
        chk("b115_busy", busy, 1);
        idle(300);
        send_frame(8'h55, 1'b1, 434, cs, c7, cst);
        idle(5);
        q = model_q(434);
        chk("b115_done", done_cnt - d0, 1);
        chk("b115_err", err_cnt - e0, 0);
        chk("b115_cfg", baudrate_cfg, q - 1);
        chk("b115_locked", locked, 1);
        chk("b115_busy_after", busy, 0);
        chk("b115_done_locked", done_lk, 1);
        chk("b115_done_busy", done_bz, 0);
        chk("b115_cfg_next", cfg_after_done, q - 1);
        chk("b115_done_time", done_cyc - cst, LAT);

        // Stop bit never rises: timeout after 2*q*SR cycles
        d0 = done_cnt; e0 = err_cnt;
        pulse_start();
        chk("tmo_locked_clr", locked, 0);
        idle(300);
        send_frame(8'h55, 1'b0, 434, cs, c7, cst);
        repeat (50) tick();
        idle(5);
        chk("tmo_err", err_cnt - e0, 1);
        chk("tmo_no_done", done_cnt - d0, 0);
        chk("tmo_time", err_cyc - c7, LAT + 2 * model_q(434) * SR);
        chk("tmo_locked", locked, 0);
        chk("tmo_cfg", baudrate_cfg, 8'h44);

        // Too slow: q reaches 257
        d0 = done_cnt; e0 = err_cnt;
        manual_cfg = 8'h5A;
        pulse_start();
        idle(300);
        c = cyc;
        rx = 1'b0;
        repeat (41667) tick();
        rx = 1'b1;
        repeat (257 * 8 * SR - 4 * SR + LAT + 20 - 41667) tick();
        chk("slow_err", err_cnt - e0, 1);
        chk("slow_time", err_cyc - c, 257 * 8 * SR - 4 * SR + LAT);
        chk("slow_no_done", done_cnt - d0, 0);
        chk("slow_locked", locked, 0);
        chk("slow_busy", busy, 0);
        chk("slow_cfg", baudrate_cfg, 8'h5A);
        idle(5);

        // q boundary cases plus random bit lengths against the model
        bits[0] = 11;
        bits[1] = 12;
        for (int i = 2; i < 7; i++) bits[i] = int'($urandom_range(250, 8));
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt; e0 = err_cnt;
            bl  = bits[i];
            man = 8'($urandom_range(255, 0));
            manual_cfg = man;
            pulse_start();
            idle(270 + int'($urandom_range(100, 0)));
            send_frame(8'h55, 1'b1, bl, cs, c7, cst);
            idle(6);
            q = model_q(bl);
            if (q >= 1 && q <= 256) begin
                chk("rnd_done", done_cnt - d0, 1);
                chk("rnd_err", err_cnt - e0, 0);
                chk("rnd_locked", locked, 1);
                chk("rnd_cfg", baudrate_cfg, q - 1);
            end else begin
                chk("rnd_done", done_cnt - d0, 0);
                chk("rnd_err", err_cnt - e0, 1);
                chk("rnd_locked", locked, 0);
                chk("rnd_cfg", baudrate_cfg, man);
            end
        end

        // Asynchronous reset in the middle of a detection
        auto_en = 1'b0; manual_cfg = 8'hA5;
        tick();
        tick();
        chk("mid_cfg_before", baudrate_cfg, 8'hA5);
        auto_en = 1'b1;
        pulse_start();
        idle(20);
        chk("mid_busy_before", busy, 1);
        rstb = 1'b0;
        #1;
        chk("mid_rst_cfg", baudrate_cfg, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
